// File: rtl/hilo_pkg.sv
// hilo_pkg: funct codes, FSM encoding and constants shared by the HI/LO unit
package hilo_pkg;
    localparam int DATA_W = 32;
    localparam logic [5:0] DIVU = 6'b011011;
    localparam logic [5:0] MFHI = 6'b010000;
    localparam logic [5:0] MTHI = 6'b010001;
    localparam logic [5:0] MFLO = 6'b010010;
    localparam logic [5:0] MTLO = 6'b010011;
    localparam logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/hilo_regfile.sv
// hilo_regfile: architectural HI/LO registers with MFHI/MFLO read mux
module hilo_regfile
    import hilo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hi_we,
    input  logic [DATA_W-1:0] hi_wd,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] lo_wd,
    input  logic              rd_hi,
    input  logic              rd_lo,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] hi, lo;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_wd;
            if (lo_we) lo <= lo_wd;
        end
    end
    assign rd_data = rd_hi ? hi : rd_lo ? lo : '0;
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: sequences DIVU into the iterative divider and serves MFHI/MFLO/MTHI/MTLO
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        stall,
    output logic        hilo_sel,
    output logic [31:0] hilo_out,
    output logic        busy,
    output logic        div_err
);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic idle, divu, mfhi, mflo, mthi, mtlo, launch, div0, done, tmo;
    assign idle   = state == IDLE;
    assign divu   = op_valid && funct == DIVU;
    assign mfhi   = op_valid && funct == MFHI;
    assign mflo   = op_valid && funct == MFLO;
    assign mthi   = op_valid && funct == MTHI;
    assign mtlo   = op_valid && funct == MTLO;
    assign launch = idle && divu && rt_data != '0;
    assign div0   = idle && divu && rt_data == '0;
    assign done   = !idle && div_done;
    // div_done takes priority over an expiring timeout
    assign tmo    = !idle && !div_done && cnt == CNT_W'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = idle ? (launch ? BUSY : IDLE) : (done || tmo ? IDLE : BUSY);
    end
    always_comb begin
        stall    = !idle && (divu || mfhi || mflo || mthi || mtlo);
        hilo_sel = idle && (mfhi || mflo);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_err      <= 1'b0;
        end else begin
            cnt       <= idle ? '0 : cnt + 1'b1;
            div_start <= launch;
            if (launch) begin
                div_dividend <= rs_data;
                div_divisor  <= rt_data;
            end
            if (tmo) div_err <= 1'b1;
        end
    end
    assign busy = !idle;
    hilo_regfile u_rf (
        .clk    (clk),
        .rst    (rst),
        .hi_we  ((idle && mthi) || div0 || done),
        .hi_wd  (done ? div_rem : rs_data),
        .lo_we  ((idle && mtlo) || div0 || done),
        .lo_wd  (done ? div_quot : div0 ? DIV0_LO : rs_data),
        .rd_hi  (mfhi),
        .rd_lo  (mflo),
        .rd_data(hilo_out)
    );
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: vector table, directed multi-cycle sequences and random ops vs. a HI/LO model
module tb_hilo_unit;
    localparam logic [5:0] F_DIVU = 6'b011011, F_MFHI = 6'b010000, F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010, F_MTLO = 6'b010011, F_ADD = 6'b100000;
    logic clk = 1'b0, rst = 1'b0;
    logic op_valid = 1'b0, div_done = 1'b0;
    logic [5:0] funct = '0;
    logic [31:0] rs_data = '0, rt_data = '0, div_quot = '0, div_rem = '0;
    logic div_start, stall, hilo_sel, busy, div_err;
    logic [31:0] div_dividend, div_divisor, hilo_out;
    int checks = 0, failures = 0;
    int div_lat = 0, pend = 0, starts = 0;
    logic [31:0] q_hold, r_hold;

    hilo_unit dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .funct(funct), .rs_data(rs_data),
        .rt_data(rt_data), .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .stall(stall), .hilo_sel(hilo_sel), .hilo_out(hilo_out), .busy(busy), .div_err(div_err)
    );

    always #5 clk = ~clk;

    // divider stand-in: answers div_lat cycles after div_start (never when div_lat==0)
    initial begin
        forever begin
            @(posedge clk);
            #1;
            div_done = 1'b0;
            if (div_start) begin
                starts++;
                q_hold = div_dividend / div_divisor;
                r_hold = div_dividend % div_divisor;
                pend = div_lat;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    div_done = 1'b1;
                    div_quot = q_hold;
                    div_rem  = r_hold;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        op_valid = v;
        funct = f;
        rs_data = rs;
        rt_data = rt;
    endtask

    task automatic wait_done(input int exp, input string name);
        int n = 0;
        while (!div_done && n < 200) begin
            tick();
            n++;
        end
        chk(name, n, exp);
    endtask

    typedef struct {
        logic v; logic [5:0] f; logic [31:0] rs, rt; logic sel; logic [31:0] out;
    } vec_t;
    vec_t vecs[13];

    initial begin
        logic [31:0] m_hi, m_lo, rs, rt;
        int n, bad;
        vecs[0]  = '{1'b1, F_MFHI, 32'h0, 32'h0, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, F_MFLO, 32'h0, 32'h0, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, F_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, F_MTLO, 32'h0BAD_F00D, 32'h0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, F_MFHI, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, F_MFLO, 32'h0, 32'h0, 1'b1, 32'h0BAD_F00D};
        vecs[6]  = '{1'b0, F_MFHI, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, F_MTHI, 32'h1, 32'h0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, F_MFHI, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, F_ADD, 32'h5, 32'h3, 1'b0, 32'h0};
        vecs[10] = '{1'b1, F_DIVU, 32'h1234, 32'h0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, F_MFLO, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF};
        vecs[12] = '{1'b1, F_MFHI, 32'h0, 32'h0, 1'b1, 32'h1234};

        // reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_div_start", div_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", div_err, 0);
        chk("rst_dividend", div_dividend, 0);
        chk("rst_divisor", div_divisor, 0);
        rst = 1'b1;
        tick();

        // single-cycle IDLE behaviour
        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].f, vecs[i].rs, vecs[i].rt);
            #1;
            chk($sformatf("vec%0d_sel", i), hilo_sel, vecs[i].sel);
            chk($sformatf("vec%0d_out", i), hilo_out, vecs[i].out);
            chk($sformatf("vec%0d_stall", i), stall, 0);
            tick();
            chk($sformatf("vec%0d_busy", i), busy, 0);
        end
        chk("div0_no_start", starts, 0);

        // DIVU 100/7, divider answers 33 cycles after start
        div_lat = 33;
        drive(1, F_DIVU, 100, 7);
        #1;
        chk("divu_issue_stall", stall, 0);
        tick();
        drive(0, 0, 0, 0);
        chk("divu_start", div_start, 1);
        chk("divu_dividend", div_dividend, 100);
        chk("divu_divisor", div_divisor, 7);
        chk("divu_busy", busy, 1);
        tick();
        chk("divu_start_pulse", div_start, 0);
        wait_done(32, "divu_latency");
        chk("divu_busy_done_cycle", busy, 1);
        tick();
        chk("divu_busy_after", busy, 0);
        drive(1, F_MFLO, 0, 0);
        #1;
        chk("divu_lo", hilo_out, 14);
        tick();
        drive(1, F_MFHI, 0, 0);
        #1;
        chk("divu_hi", hilo_out, 2);
        tick();
        chk("divu_one_start", starts, 1);

        // MFHI held behind an outstanding divide
        div_lat = 10;
        drive(1, F_DIVU, 32'hFFFF_FFFF, 32'h10);
        tick();
        drive(1, F_MFHI, 0, 0);
        #1;
        chk("held_stall", stall, 1);
        chk("held_sel", hilo_sel, 0);
        n = 0;
        bad = 0;
        while (!div_done && n < 200) begin
            if (!stall) bad++;
            tick();
            n++;
        end
        chk("held_latency", n, 10);
        chk("held_stall_done_cycle", stall, 1);
        chk("held_stall_gaps", bad, 0);
        tick();
        chk("held_release", stall, 0);
        chk("held_sel_after", hilo_sel, 1);
        chk("held_hi", hilo_out, 32'h0000_000F);
        drive(1, F_MFLO, 0, 0);
        #1;
        chk("held_lo", hilo_out, 32'h0FFF_FFFF);
        tick();

        // MTHI during BUSY waits, then overwrites the divide result
        div_lat = 5;
        drive(1, F_DIVU, 50, 3);
        tick();
        drive(1, F_MTHI, 32'hDEAD_BEEF, 0);
        #1;
        chk("mt_busy_stall", stall, 1);
        wait_done(5, "mt_latency");
        tick();
        tick();
        drive(1, F_MFLO, 0, 0);
        #1;
        chk("mt_div_lo", hilo_out, 16);
        tick();
        drive(1, F_MTLO, 32'h0BAD_F00D, 0);
        tick();
        drive(1, F_MFHI, 0, 0);
        #1;
        chk("mt_hi", hilo_out, 32'hDEAD_BEEF);
        tick();
        drive(1, F_MFLO, 0, 0);
        #1;
        chk("mt_lo", hilo_out, 32'h0BAD_F00D);
        tick();

        // divider never answers: timeout after 64 BUSY cycles
        div_lat = 0;
        drive(1, F_DIVU, 9, 3);
        tick();
        drive(0, 0, 0, 0);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("tmo_busy_cycles", n, 64);
        chk("tmo_err", div_err, 1);
        chk("tmo_busy", busy, 0);
        drive(1, F_MFHI, 0, 0);
        #1;
        chk("tmo_hi", hilo_out, 32'hDEAD_BEEF);
        tick();
        drive(1, F_MFLO, 0, 0);
        #1;
        chk("tmo_lo", hilo_out, 32'h0BAD_F00D);
        tick();

        // async reset in the middle of BUSY
        drive(1, F_DIVU, 8, 2);
        tick();
        drive(0, 0, 0, 0);
        tick();
        chk("ar_busy_before", busy, 1);
        chk("ar_err_sticky", div_err, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_err", div_err, 0);
        chk("ar_dividend", div_dividend, 0);
        chk("ar_divisor", div_divisor, 0);
        drive(1, F_MFHI, 0, 0);
        #1;
        chk("ar_sel", hilo_sel, 1);
        chk("ar_hi", hilo_out, 0);
        drive(0, 0, 0, 0);
        rst = 1'b1;
        tick();

        // random ops against a HI/LO model built from the instruction semantics
        m_hi = 0;
        m_lo = 0;
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 9);
            rs = $urandom;
            if (r <= 2) begin
                rt = ($urandom_range(0, 3) == 0) ? 32'h0 :
                     ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300));
                div_lat = $urandom_range(1, 8);
                drive(1, F_DIVU, rs, rt);
                #1;
                chk("rnd_divu_stall", stall, 0);
                tick();
                if (rt == 0) begin
                    m_hi = rs;
                    m_lo = 32'hFFFF_FFFF;
                    chk("rnd_div0_busy", busy, 0);
                end else begin
                    drive(0, 0, 0, 0);
                    wait_done(div_lat, "rnd_latency");
                    tick();
                    m_hi = rs % rt;
                    m_lo = rs / rt;
                end
            end else if (r == 3 || r == 4) begin
                drive(1, r == 3 ? F_MTHI : F_MTLO, rs, 0);
                tick();
                if (r == 3) m_hi = rs;
                else m_lo = rs;
            end else if (r <= 7) begin
                drive(1, r == 7 ? F_MFLO : F_MFHI, 0, 0);
                #1;
                chk("rnd_mf_sel", hilo_sel, 1);
                chk(r == 7 ? "rnd_mflo" : "rnd_mfhi", hilo_out, r == 7 ? m_lo : m_hi);
                tick();
            end else begin
                drive(r == 8, r == 8 ? F_ADD : F_MTHI, rs, 0);
                tick();
            end
        end
        drive(1, F_MFHI, 0, 0);
        #1;
        chk("rnd_final_hi", hilo_out, m_hi);
        drive(1, F_MFLO, 0, 0);
        #1;
        chk("rnd_final_lo", hilo_out, m_lo);
        drive(0, 0, 0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
